// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state codes and counter sizing.
package pll_seq_pkg;

  // Symbolic view of the sequencer states, kept in step with the codes below.
  typedef enum logic [2:0] {
    StHold  = 3'd0,
    StRel   = 3'd1,
    StWait  = 3'd2,
    StRun   = 3'd3,
    StFault = 3'd4
  } seq_state_e;

  // Legacy-compatible state codes; these values appear on the state output.
  localparam logic [2:0] S_HOLD  = 3'd0;
  localparam logic [2:0] S_REL   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  // Width that holds the largest of the three cycle counts without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; clears to 0 on reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; second stage gives a clean level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings up a chain of dependent PLLs one at a time, then releases the system reset.
// Define PLL_SEQ_TIMEOUT_EN to add a per-channel lock timeout with a sticky fault state.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned N_PLL        = 2,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_PLL-1:0] pll_locked,
  input  logic             sw_restart,
  output logic [N_PLL-1:0] pll_reset,
  output logic             sys_reset,
  output logic [N_PLL-1:0] locked_sync,
  output logic [2:0]       state,
  output logic             fault,
  output logic [2:0]       fault_ch
);

  localparam int unsigned   CW          = cnt_width(HOLD_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [2:0]    CH_LAST     = 3'(N_PLL - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       ch_q, ch_d;
  logic [N_PLL-1:0] pll_reset_q, pll_reset_d;
  logic             sys_reset_q, sys_reset_d;
  logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  logic [CW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             fault_q, fault_d;
  logic [2:0]       fault_ch_q, fault_ch_d;
`endif

  logic             lock_cur;
  logic             any_low;
  logic [2:0]       low_ch;
  logic [N_PLL-1:0] ch_oh, ch_next_oh, mask_from_ch, mask_from_low;

  sync_2ff #(
    .WIDTH(N_PLL)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (pll_locked),
    .q      (locked_sync)
  );

  // Per-channel decode: current channel's lock, lowest unlocked channel, reset masks.
  always_comb begin
    lock_cur      = 1'b0;
    low_ch        = '0;
    ch_oh         = '0;
    ch_next_oh    = '0;
    mask_from_ch  = '0;
    mask_from_low = '0;
    any_low       = ~&locked_sync;
    for (int j = N_PLL - 1; j >= 0; j--) begin
      ch_oh[j]        = (ch_q == 3'(j));
      ch_next_oh[j]   = ((ch_q + 3'd1) == 3'(j));
      mask_from_ch[j] = (j >= int'(ch_q));
      if (ch_q == 3'(j)) lock_cur = locked_sync[j];
      if (!locked_sync[j]) low_ch = 3'(j);
    end
    for (int j = 0; j < N_PLL; j++) begin
      mask_from_low[j] = (j >= int'(low_ch));
    end
  end

  // Sequencer next state; software restart overrides every other event.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pll_reset_d = pll_reset_q;
    sys_reset_d = sys_reset_q;
    hold_cnt_d  = hold_cnt_q;
    lock_cnt_d  = lock_cnt_q;
`ifdef PLL_SEQ_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    fault_d     = fault_q;
    fault_ch_d  = fault_ch_q;
`endif
    if (sw_restart) begin
      state_d     = S_HOLD;
      ch_d        = '0;
      pll_reset_d = '1;
      sys_reset_d = 1'b1;
      hold_cnt_d  = '0;
      lock_cnt_d  = '0;
`ifdef PLL_SEQ_TIMEOUT_EN
      tmo_cnt_d   = '0;
      fault_d     = 1'b0;
      fault_ch_d  = '0;
`endif
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d     = S_REL;
            pll_reset_d = pll_reset_q & ~ch_oh;
          end else if (hold_cnt_q != CNT_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        S_REL: begin
          state_d    = S_WAIT;
          hold_cnt_d = '0;
          lock_cnt_d = '0;
`ifdef PLL_SEQ_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
        S_WAIT: begin
          if (lock_cur) begin
            if (lock_cnt_q == STABLE_LAST) begin
              lock_cnt_d = '0;
              if (ch_q == CH_LAST) begin
                state_d     = S_RUN;
                sys_reset_d = 1'b0;
              end else begin
                state_d     = S_REL;
                ch_d        = ch_q + 3'd1;
                pll_reset_d = pll_reset_q & ~ch_next_oh;
              end
            end else if (lock_cnt_q != CNT_MAX) begin
              lock_cnt_d = lock_cnt_q + 1'b1;
            end
          end else begin
            lock_cnt_d = '0;
          end
`ifdef PLL_SEQ_TIMEOUT_EN
          // A successful lock in the same cycle wins over the timeout.
          if (state_d == S_WAIT) begin
            if (tmo_cnt_q == TMO_LAST) begin
              state_d     = S_FAULT;
              fault_d     = 1'b1;
              fault_ch_d  = ch_q;
              pll_reset_d = pll_reset_q | mask_from_ch;
            end else if (tmo_cnt_q != CNT_MAX) begin
              tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
          end
`endif
        end
        S_RUN: begin
          if (any_low) begin
            state_d     = S_HOLD;
            ch_d        = low_ch;
            pll_reset_d = pll_reset_q | mask_from_low;
            sys_reset_d = 1'b1;
            hold_cnt_d  = '0;
          end
        end
        S_FAULT: begin
          // Parked until software restart.
        end
        default: begin
          state_d     = S_HOLD;
          ch_d        = '0;
          pll_reset_d = '1;
          sys_reset_d = 1'b1;
          hold_cnt_d  = '0;
        end
      endcase
    end
  end

  // State registers; reset parks everything in hold with all resets asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_HOLD;
      ch_q        <= '0;
      pll_reset_q <= '1;
      sys_reset_q <= 1'b1;
      hold_cnt_q  <= '0;
      lock_cnt_q  <= '0;
`ifdef PLL_SEQ_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      fault_q     <= 1'b0;
      fault_ch_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      hold_cnt_q  <= hold_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
`ifdef PLL_SEQ_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      fault_q     <= fault_d;
      fault_ch_q  <= fault_ch_d;
`endif
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_reset = sys_reset_q;
  assign state     = state_q;
`ifdef PLL_SEQ_TIMEOUT_EN
  assign fault     = fault_q;
  assign fault_ch  = fault_ch_q;
`else
  assign fault     = 1'b0;
  assign fault_ch  = 3'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer against a behavioural model.
// Honours PLL_SEQ_TIMEOUT_EN the same way as the design.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  localparam int NP     = 2;
  localparam int HOLD   = 4;
  localparam int STABLE = 3;
  localparam int TMO    = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] pll_locked;
  logic       sw_restart;
  logic [1:0] pll_reset;
  logic       sys_reset;
  logic [1:0] locked_sync;
  logic [2:0] state;
  logic       fault;
  logic [2:0] fault_ch;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode numbers follow the externally visible state codes.
  int         m_mode, m_ch, m_el, m_run, m_fault, m_fault_ch;
  logic [1:0] m_sync, m_d1;

  pll_reset_sequencer #(
    .N_PLL       (NP),
    .HOLD_CYCLES (HOLD),
    .LOCK_STABLE (STABLE),
    .LOCK_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .sw_restart (sw_restart),
    .pll_reset  (pll_reset),
    .sys_reset  (sys_reset),
    .locked_sync(locked_sync),
    .state      (state),
    .fault      (fault),
    .fault_ch   (fault_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ch = 0; m_el = 0; m_run = 0; m_fault = 0; m_fault_ch = 0;
    m_sync = 2'b00; m_d1 = 2'b00;
  endtask

  // One clock edge of the model, using the inputs present before the edge.
  task automatic model_step(input logic [1:0] lk, input logic sw);
    logic [1:0] s;
    s = m_sync;
    if (sw) begin
      m_mode = 0; m_ch = 0; m_el = 0; m_run = 0; m_fault = 0; m_fault_ch = 0;
    end else begin
      case (m_mode)
        0: begin
          m_el++;
          if (m_el == HOLD) begin m_mode = 1; m_el = 0; end
        end
        1: begin m_mode = 2; m_el = 0; m_run = 0; end
        2: begin
          m_run = s[m_ch] ? m_run + 1 : 0;
          m_el++;
          if (m_run == STABLE) begin
            if (m_ch == NP - 1) m_mode = 3;
            else begin m_ch++; m_mode = 1; end
          end
`ifdef PLL_SEQ_TIMEOUT_EN
          else if (m_el == TMO) begin
            m_mode = 4; m_fault = 1; m_fault_ch = m_ch;
          end
`endif
        end
        3: begin
          if (s != 2'b11) begin
            for (int k = NP - 1; k >= 0; k--) if (!s[k]) m_ch = k;
            m_mode = 0; m_el = 0;
          end
        end
        default: ;
      endcase
    end
    m_sync = m_d1;
    m_d1   = lk;
  endtask

  // Channels still held: from ch upward in hold/fault, above ch while releasing/waiting.
  function automatic logic [1:0] exp_prst();
    logic [1:0] r;
    r = 2'b00;
    for (int j = 0; j < NP; j++) begin
      if (m_mode == 0 || m_mode == 4) r[j] = (j >= m_ch);
      else if (m_mode == 1 || m_mode == 2) r[j] = (j > m_ch);
    end
    return r;
  endfunction

  task automatic compare_all();
    check("state", state, m_mode);
    check("pll_reset", pll_reset, exp_prst());
    check("sys_reset", sys_reset, m_mode != 3);
    check("locked_sync", locked_sync, m_sync);
    check("fault", fault, m_fault);
    check("fault_ch", fault_ch, m_fault_ch);
  endtask

  task automatic tick();
    logic [1:0] lk;
    logic       sw;
    lk = pll_locked;
    sw = sw_restart;
    @(posedge clk);
    model_step(lk, sw);
    #1;
    compare_all();
    sw_restart = 1'b0;
  endtask

  task automatic run_until(input int mode, input int budget);
    int n;
    n = 0;
    while (m_mode != mode && n < budget) begin
      tick();
      n++;
    end
    check("reach_state", state, mode);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] glitch_pat;
    int         kind, len;
    logic [1:0] cst;

    reset_n    = 1'b0;
    pll_locked = 2'b11;
    sw_restart = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_pll_reset", pll_reset, 2'b11);
    reset_n = 1'b1;

    // Nominal bring-up with both locks held.
    repeat (HOLD) tick();
    check("nom_prst0", pll_reset, 2'b10);
    run_until(3, 40);
    check("nom_sys", sys_reset, 1'b0);

    // Channel 1 lock loss in run: re-sequence channel 1 only.
    pll_locked = 2'b01;
    repeat (3) tick();
    check("loss_prst", pll_reset, 2'b10);
    check("loss_sys", sys_reset, 1'b1);
    pll_locked = 2'b11;
    run_until(3, 40);

    // Restart coinciding with channel 0 lock loss.
    pll_locked = 2'b10;
    repeat (2) tick();
    sw_restart = 1'b1;
    tick();
    check("simul_prst", pll_reset, 2'b11);
    check("simul_state", state, 3'd0);

    // Lock glitch on channel 0 delays release of channel 1.
    run_until(2, 20);
    glitch_pat = 8'b1111_1011;
    for (int i = 0; i < 8; i++) begin
      pll_locked = {1'b1, glitch_pat[i]};
      tick();
      if (i == 6) begin
        check("glitch_state", state, 3'd2);
        check("glitch_prst", pll_reset, 2'b10);
      end
    end
    check("glitch_adv", state, 3'd1);

    // Channel 1 never locks.
    pll_locked = 2'b01;
`ifdef PLL_SEQ_TIMEOUT_EN
    run_until(4, 40);
    check("tmo_fault", fault, 1'b1);
    check("tmo_ch", fault_ch, 3'd1);
`else
    repeat (40) tick();
    check("notmo_state", state, 3'd2);
    check("notmo_fault", fault, 1'b0);
`endif
    sw_restart = 1'b1;
    tick();
    check("restart_fault", fault, 1'b0);
    check("restart_prst", pll_reset, 2'b11);

    // Asynchronous reset in the middle of a wait.
    pll_locked = 2'b11;
    run_until(2, 20);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("arst_prst", pll_reset, 2'b11);
    check("arst_state", state, 3'd0);
    @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;

    // Randomised segments of lock behaviour with occasional restarts.
    for (int seg = 0; seg < 60; seg++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(5, 60);
      cst  = 2'($urandom);
      for (int i = 0; i < len; i++) begin
        case (kind)
          0: pll_locked = 2'b11;
          1: pll_locked = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
          2: pll_locked = cst;
          default: pll_locked = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b11;
        endcase
        sw_restart = ($urandom_range(0, 79) == 0);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameters SHALL be: N_PLL, default 2, number of chained PLL channels (1..8); HOLD_CYCLES, default 16, reset pulse width; LOCK_STABLE, default 8, consecutive locked cycles required; LOCK_TIMEOUT, default 65535, cycles allowed per channel to lock.
REQ-002 Port clk, input, 1, single clock for all logic.
REQ-003 Port reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port pll_locked, input, N_PLL, asynchronous PLL lock indicators; channel k depends on channel k-1.
REQ-005 Port sw_restart, input, 1, single-cycle software restart pulse.
REQ-006 Port pll_reset, output, N_PLL, active-high per-PLL reset.
REQ-007 Port sys_reset, output, 1, active-high downstream reset (TDC, soft CPU).
REQ-008 Port locked_sync, output, N_PLL, synchronised pll_locked.
REQ-009 Port state, output, 3, current FSM state code.
REQ-010 Port fault, output, 1, lock-timeout flag; fault_ch, output, 3, channel that timed out.

Function
REQ-011 pll_locked SHALL pass through a 2-flop synchroniser; all decisions SHALL use locked_sync.
REQ-012 FSM states SHALL be S_HOLD, S_REL, S_WAIT, S_RUN, S_FAULT, encoded 0..4.
REQ-013 S_HOLD: pll_reset[j]=1 for j>=ch, sys_reset=1; after HOLD_CYCLES cycles -> S_REL.
REQ-014 S_REL: pll_reset[ch] SHALL clear on the transition edge; the lock and timeout counters SHALL clear; next state S_WAIT.
REQ-015 S_WAIT: when locked_sync[ch] has been high for LOCK_STABLE consecutive cycles, the block SHALL go to S_REL with ch+1, or to S_RUN if ch==N_PLL-1; a low sample SHALL zero the stable counter.
REQ-016 sys_reset SHALL deassert on the clock edge that enters S_RUN, and only then.
REQ-017 S_RUN: if any locked_sync[k] falls, sys_reset and pll_reset[j] for j>=k SHALL assert on the next edge; ch SHALL become the lowest such k; next state S_HOLD.
REQ-018 sw_restart in any state SHALL force ch=0, all resets asserted, S_HOLD, and fault cleared; it SHALL take priority over lock loss and timeout in the same cycle.
REQ-019 Locked inputs of channels above ch SHALL be ignored outside S_RUN.
REQ-020 Counters SHALL saturate and never wrap; the counter width is derived by $clog2 of the largest parameter.

Reset
REQ-021 While reset_n is low, pll_reset SHALL be all ones, sys_reset=1, state=S_HOLD, ch=0, fault=0, fault_ch=0, all counters 0, and synchroniser flops 0.
REQ-022 After reset_n rises, the sequence SHALL start from S_HOLD with the full HOLD_CYCLES count.

Configuration
REQ-023 Macro PLL_SEQ_TIMEOUT_EN defined: in S_WAIT, if the timeout counter reaches LOCK_TIMEOUT, the block SHALL go to S_FAULT, set fault=1 and fault_ch=ch, and keep pll_reset[j]=1 for j>=ch and sys_reset=1 until sw_restart.
REQ-024 Macro undefined: there SHALL be no timeout counter and S_FAULT is unreachable; S_WAIT waits indefinitely, and fault and fault_ch are tied to 0.

Structure
REQ-025 Package pll_seq_pkg SHALL hold the state enum, the state code constants, and the counter width function.
REQ-026 Sub-module sync_2ff SHALL be parametrised by width and reset to 0 asynchronously.

Verification
All scenarios use N_PLL=2, HOLD_CYCLES=4, LOCK_STABLE=3, LOCK_TIMEOUT=20.
REQ-027 Nominal bring-up: release reset with pll_locked=2'b11 held -> pll_reset[0] falls after 4 cycles, then pll_reset[1] falls, then sys_reset=0 with state=3.
REQ-028 Lock glitch: locked[0] high for 2 cycles, low for 1 cycle, then high -> no advance until 3 consecutive high cycles; pll_reset[1] stays 1 meanwhile.
REQ-029 Lock loss in S_RUN: drop locked[1] -> sys_reset=1 and pll_reset=2'b10 within 3 cycles (synchroniser plus 1 edge); channel 1 re-sequences and sys_reset returns to 0.
REQ-030 Timeout, macro defined: locked[1] held 0 -> after 20 cycles in S_WAIT, fault=1, fault_ch=1, state=4; sw_restart -> fault=0, pll_reset=2'b11.
REQ-031 Simultaneous events: sw_restart in the same cycle as the locked[0] fall during S_RUN -> ch=0 full restart, pll_reset=2'b11.
REQ-032 Mid-sequence reset: reset_n pulsed low during S_WAIT -> all outputs return to reset values immediately (asynchronously).
